// File: rtl/bus_mem_responder_if.sv
// Request/response bundle for the single-master core bus.
// Signals:
//   i_bus_en  - request valid, fields held stable by the master until ack
//   i_wr_en   - 1 = write, 0 = read
//   i_addr    - byte address (bits [1:0] ignored by the responder)
//   i_wr_data - write data
//   i_byte_en - write byte-lane mask
//   o_ack     - one-cycle completion pulse
//   o_rd_data - read data, valid in the ack cycle
interface bus_mem_responder_if;
  logic        i_bus_en;
  logic        i_wr_en;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic [3:0]  i_byte_en;
  logic        o_ack;
  logic [31:0] o_rd_data;

  modport master (
    output i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
    input  o_ack, o_rd_data
  );

  modport slave (
    input  i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
    output o_ack, o_rd_data
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Word-addressed on-chip RAM answering core-bus requests after WAIT_CYCLES
// wait states, with an optional memory-mapped machine timer.
// Optional feature macro: BUS_RESP_TIMER_EN (adds mtime/mtimecmp at TIMER_BASE
// and drives o_tip; without it o_tip is tied low and TIMER_BASE does not exist).
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset
//   bus    - slave side of the core bus (request in, ack/read data out)
//   o_tip  - timer interrupt pending
module bus_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
`ifdef BUS_RESP_TIMER_EN
  ,
  parameter logic [31:0] TIMER_BASE  = 32'h4000_0000
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  bus_mem_responder_if.slave    bus,
  output logic                  o_tip
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, RECOVER} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               ack_q, ack_d;
  logic [31:0]        rd_q, rd_d;

  logic [31:0]        mem [DEPTH];

  // Request as seen this cycle: live bus fields while idle, latched copy otherwise
  logic               req_wr_c;
  logic [31:0]        req_addr_c;
  logic [31:0]        req_off_c;
  logic               in_range_c;
  logic [IDX_W-1:0]   idx_c;
  logic               timer_hit_c;
  logic [31:0]        rd_word_c;
  logic               mem_we_c;

  assign req_wr_c   = (state_q == IDLE) ? bus.i_wr_en : wr_q;
  assign req_addr_c = (state_q == IDLE) ? bus.i_addr  : addr_q;
  // Unsigned wrap makes addresses below BASE_ADDR land out of range
  assign req_off_c  = req_addr_c - BASE_ADDR;
  assign in_range_c = ({2'b00, req_off_c} < (34'(DEPTH) << 2));
  assign idx_c      = req_off_c[IDX_W+1:2];

  function automatic logic [31:0] merge_bytes(logic [31:0] old_w, logic [31:0] new_w,
                                              logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

`ifdef BUS_RESP_TIMER_EN
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        tip_q, tip_d;
  logic [31:0] timer_off_c;
  logic        tim_we_c;

  assign timer_off_c = req_addr_c - TIMER_BASE;
  assign timer_hit_c = (timer_off_c < 32'd16);
  assign tim_we_c    = (state_q == ACK) && wr_q && timer_hit_c;

  // Free-running counter; a write to an mtime half replaces that cycle's increment
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    tip_d      = (mtime_q >= mtimecmp_q);
    if (tim_we_c) begin
      case (timer_off_c[3:2])
        2'd0: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_q, be_q)};
        2'd1: mtime_d = {merge_bytes(mtime_q[63:32], wdata_q, be_q), mtime_q[31:0]};
        2'd2: mtimecmp_d = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], wdata_q, be_q)};
        default: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], wdata_q, be_q),
                               mtimecmp_q[31:0]};
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      tip_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      tip_q      <= tip_d;
    end
  end

  assign o_tip = tip_q;
`else
  assign timer_hit_c = 1'b0;
  assign o_tip       = 1'b0;
`endif

  // Read mux: timer window wins over RAM decode
  always_comb begin
    rd_word_c = 32'd0;
`ifdef BUS_RESP_TIMER_EN
    if (timer_hit_c) begin
      case (timer_off_c[3:2])
        2'd0:    rd_word_c = mtime_q[31:0];
        2'd1:    rd_word_c = mtime_q[63:32];
        2'd2:    rd_word_c = mtimecmp_q[31:0];
        default: rd_word_c = mtimecmp_q[63:32];
      endcase
    end else
`endif
    if (in_range_c) begin
      rd_word_c = mem[idx_c];
    end
  end

  // State and request registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      ack_q   <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
  end

  // Next state, wait counter and request latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (bus.i_bus_en) begin
          wr_d    = bus.i_wr_en;
          addr_d  = bus.i_addr;
          wdata_d = bus.i_wr_data;
          be_d    = bus.i_byte_en;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if ((32'(cnt_q) + 32'd1) >= WAIT_CYCLES) begin
          cnt_d   = '0;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK:     state_d = RECOVER;
      default: state_d = IDLE;
    endcase
  end

  // Ack and read data are registered so they are valid throughout the ACK cycle
  always_comb begin
    ack_d = (state_d == ACK);
    rd_d  = rd_q;
    if (state_d == ACK) begin
      rd_d = req_wr_c ? 32'd0 : rd_word_c;
    end
  end

  // RAM write commits at the edge ending ACK unless reset aborts it
  assign mem_we_c = !i_rst && (state_q == ACK) && wr_q && in_range_c && !timer_hit_c;

  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= merge_bytes(mem[idx_c], wdata_q, be_q);
    end
  end

  assign bus.o_ack     = ack_q;
  assign bus.o_rd_data = rd_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

  logic clk;
  logic rst;
  logic tip;

  bus_mem_responder_if bus ();

  bus_mem_responder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave),
    .o_tip (tip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void add(string nm, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, logic [31:0] exp_rd);
    vec_t v;
    v.name = nm; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.exp_rd = exp_rd;
    vecs.push_back(v);
  endfunction

  // Drive a request (called #1 after a posedge) and wait for its ack.
  // lat = posedges from driving the request until ack is seen; -1 on timeout.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic hold,
                        output logic [31:0] rd, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    bus.i_bus_en  = 1'b1;
    bus.i_wr_en   = wr;
    bus.i_addr    = addr;
    bus.i_wr_data = wdata;
    bus.i_byte_en = be;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.o_ack) got = 1'b1;
    end
    if (!got) lat = -1;
    rd = bus.o_rd_data;
    if (!hold) bus.i_bus_en = 1'b0;
  endtask

  task automatic count_acks(input int cycles, output int acks);
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.o_ack) acks++;
    end
  endtask

  logic [31:0] rd;
  logic [31:0] rd_prev;
  int          lat;
  int          acks;
  int          gap;
  bit          got;

  initial begin
    rst           = 1'b1;
    bus.i_bus_en  = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_addr    = 32'd0;
    bus.i_wr_data = 32'd0;
    bus.i_byte_en = 4'd0;

    add("wr_full_10",  1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    32'h0);
    add("rd_10",       1'b0, 32'h10,       32'h0,        4'hF,    32'hDEADBEEF);
    add("wr_lane1_10", 1'b1, 32'h10,       32'h0000AA00, 4'b0010, 32'h0);
    add("rd_12",       1'b0, 32'h12,       32'h0,        4'h0,    32'hDEADAAEF);
    add("wr_0",        1'b1, 32'h0,        32'hCAFEF00D, 4'hF,    32'h0);
    add("rd_oor",      1'b0, 32'h1000,     32'h0,        4'hF,    32'h0);
    add("wr_oor",      1'b1, 32'h1000,     32'h12345678, 4'hF,    32'h0);
    add("rd_0_a",      1'b0, 32'h0,        32'h0,        4'hF,    32'hCAFEF00D);
    add("wr_be0",      1'b1, 32'h0,        32'hFFFFFFFF, 4'h0,    32'h0);
    add("rd_0_b",      1'b0, 32'h0,        32'h0,        4'hF,    32'hCAFEF00D);
    add("wr_last",     1'b1, 32'hFFC,      32'hA5A5A5A5, 4'hF,    32'h0);
    add("rd_last",     1'b0, 32'hFFC,      32'h0,        4'hF,    32'hA5A5A5A5);
    add("wr_4_clr",    1'b1, 32'h4,        32'h0,        4'hF,    32'h0);
    add("wr_4_b03",    1'b1, 32'h4,        32'h11223344, 4'b1001, 32'h0);
    add("rd_4",        1'b0, 32'h4,        32'h0,        4'hF,    32'h11000044);
    add("wr_20_clr",   1'b1, 32'h20,       32'h0,        4'hF,    32'h0);
    add("rd_below",    1'b0, 32'hFFFFFFFC, 32'h0,        4'hF,    32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(bus.o_ack), 32'd0);
    chk("reset_rd", bus.o_rd_data, 32'd0);
    chk("reset_tip", 32'(tip), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, rd, lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
      chk({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
      @(posedge clk); #1;
      chk({vecs[i].name, "_pulse"}, 32'(bus.o_ack), 32'd0);
      chk({vecs[i].name, "_hold"}, bus.o_rd_data, rd);
`ifndef BUS_RESP_TIMER_EN
      chk({vecs[i].name, "_tip"}, 32'(tip), 32'd0);
`endif
      @(posedge clk); #1;
    end

    // Master keeps bus_en one cycle past ack: serviced only once
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, rd, lat);
    chk("hold_lat", 32'(lat), 32'd2);
    chk("hold_rd", rd, 32'hDEADAAEF);
    @(posedge clk); #1;
    bus.i_bus_en = 1'b0;
    count_acks(6, acks);
    chk("hold_extra_acks", 32'(acks), 32'd0);

    // Continuously held request: next ack only after RECOVER (3+WAIT cycles apart)
    do_req(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, rd, lat);
    chk("b2b_first_lat", 32'(lat), 32'd2);
    rd_prev = rd;
    gap = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      gap++;
      if (bus.o_ack) got = 1'b1;
    end
    if (!got) gap = -1;
    bus.i_bus_en = 1'b0;
    chk("b2b_gap", 32'(gap), 32'd4);
    chk("b2b_rd", bus.o_rd_data, rd_prev);
    count_acks(6, acks);
    chk("b2b_extra_acks", 32'(acks), 32'd0);

    // Reset during WAIT aborts the write
    bus.i_bus_en  = 1'b1;
    bus.i_wr_en   = 1'b1;
    bus.i_addr    = 32'h20;
    bus.i_wr_data = 32'h55555555;
    bus.i_byte_en = 4'hF;
    @(posedge clk); #1;
    chk("rstwait_no_ack_a", 32'(bus.o_ack), 32'd0);
    rst = 1'b1;
    bus.i_bus_en = 1'b0;
    @(posedge clk); #1;
    chk("rstwait_no_ack_b", 32'(bus.o_ack), 32'd0);
    rst = 1'b0;
    count_acks(5, acks);
    chk("rstwait_acks", 32'(acks), 32'd0);

    // Reset and request on the same edge: reset wins
    rst           = 1'b1;
    bus.i_bus_en  = 1'b1;
    bus.i_wr_en   = 1'b1;
    bus.i_addr    = 32'h20;
    bus.i_wr_data = 32'h77777777;
    bus.i_byte_en = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_bus_en = 1'b0;
    count_acks(5, acks);
    chk("rstreq_acks", 32'(acks), 32'd0);
    chk("rstreq_rd_cleared", bus.o_rd_data, 32'd0);

    do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, lat);
    chk("after_rst_lat", 32'(lat), 32'd2);
    chk("after_rst_rd_20", rd, 32'h0);
    @(posedge clk); #1;
`ifndef BUS_RESP_TIMER_EN
    chk("final_tip", 32'(tip), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
